// File: rtl/mem_wb_if.sv
// Bundle of signals between execute, the memory/writeback stage, data memory
// and the register file/CPSR.
interface mem_wb_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32:0]           alu_result;
    logic [31:0]           cpsr_in;
    logic [31:0]           store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic                  set_flags;
    logic                  is_load;
    logic                  is_store;
    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ack;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [31:0]           rf_wdata;
    logic                  cpsr_we;
    logic [31:0]           cpsr_wdata;
    logic                  mem_fault;

    modport slave (
        input  in_valid, alu_result, cpsr_in, store_data, rd, rd_we, set_flags,
               is_load, is_store, mem_rdata, mem_ack,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr,
               rf_wdata, cpsr_we, cpsr_wdata, mem_fault
    );

    modport master (
        output in_valid, alu_result, cpsr_in, store_data, rd, rd_we, set_flags,
               is_load, is_store, mem_rdata, mem_ack,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr,
               rf_wdata, cpsr_we, cpsr_wdata, mem_fault
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: optional data-memory access over a req/ack handshake,
// then a one-cycle register-file and CPSR write; faults on misalignment or timeout.
module mem_wb_stage #(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input logic     clk,
    input logic     reset,
    mem_wb_if.slave bus
);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM, WB, FAULT} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      waitCnt_q;
    logic                  isLoad_q;
    logic                  isStore_q;
    logic                  rdWe_q;
    logic                  setFlags_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [31:0]           alu_q;
    logic [31:0]           cpsrIn_q;

    logic                  in_ready_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [31:0]           mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [31:0]           rf_wdata_q;
    logic                  cpsr_we_q;
    logic [31:0]           cpsr_wdata_q;
    logic                  mem_fault_q;

    logic        memOp;
    logic        misaligned;
    logic [31:0] loadCpsr;
    logic        unusedOverflow;

    assign memOp          = bus.is_load | bus.is_store;
    assign misaligned     = (bus.alu_result[1:0] != 2'b00);
    // Loads only report N and Z; C and V are cleared.
    assign loadCpsr       = {bus.mem_rdata[31], (bus.mem_rdata == 32'd0), 30'd0};
    assign unusedOverflow = bus.alu_result[32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            waitCnt_q    <= '0;
            isLoad_q     <= 1'b0;
            isStore_q    <= 1'b0;
            rdWe_q       <= 1'b0;
            setFlags_q   <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            cpsrIn_q     <= '0;
            in_ready_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            cpsr_we_q    <= 1'b0;
            cpsr_wdata_q <= '0;
            mem_fault_q  <= 1'b0;
        end else begin
            rf_we_q     <= 1'b0;
            cpsr_we_q   <= 1'b0;
            mem_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        isLoad_q   <= bus.is_load;
                        isStore_q  <= bus.is_store;
                        rdWe_q     <= bus.rd_we;
                        setFlags_q <= bus.set_flags;
                        rd_q       <= bus.rd;
                        alu_q      <= bus.alu_result[31:0];
                        cpsrIn_q   <= bus.cpsr_in;
                        if (memOp && misaligned) begin
                            state_q     <= FAULT;
                            mem_fault_q <= 1'b1;
                        end else if (memOp) begin
                            state_q     <= MEM;
                            waitCnt_q   <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.is_store;
                            mem_addr_q  <= bus.alu_result[31:0];
                            mem_wdata_q <= bus.store_data;
                        end else begin
                            state_q      <= WB;
                            rf_we_q      <= bus.rd_we;
                            rf_waddr_q   <= bus.rd;
                            rf_wdata_q   <= bus.alu_result[31:0];
                            cpsr_we_q    <= bus.set_flags;
                            cpsr_wdata_q <= bus.cpsr_in;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                MEM: begin
                    // Ack is checked before the timeout so a last-cycle ack still succeeds.
                    if (bus.mem_ack) begin
                        state_q      <= WB;
                        mem_req_q    <= 1'b0;
                        rf_we_q      <= rdWe_q & ~isStore_q;
                        rf_waddr_q   <= rd_q;
                        rf_wdata_q   <= isLoad_q ? bus.mem_rdata : alu_q;
                        cpsr_we_q    <= setFlags_q;
                        cpsr_wdata_q <= isLoad_q ? loadCpsr : cpsrIn_q;
                    end else if (waitCnt_q == LAST_WAIT) begin
                        state_q     <= FAULT;
                        mem_req_q   <= 1'b0;
                        mem_fault_q <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                WB, FAULT: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.cpsr_we    = cpsr_we_q;
    assign bus.cpsr_wdata = cpsr_wdata_q;
    assign bus.mem_fault  = mem_fault_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table of complete instructions plus
// hand-written reset, misalignment, timeout and reset-during-access sequences.
module tb_mem_wb_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_wb_if #(.REG_ADDR_W(4)) bus();

    mem_wb_stage #(.REG_ADDR_W(4), .MEM_TIMEOUT(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        isLoad;
        logic        isStore;
        logic [32:0] alu;
        logic [31:0] storeData;
        logic [3:0]  rd;
        logic        rdWe;
        logic        setFlags;
        logic [31:0] cpsrIn;
        int          ackDelay;
        logic [31:0] rdata;
        logic        expRfWe;
        logic [31:0] expRfWdata;
        logic        expCpsrWe;
        logic [31:0] expCpsr;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        bus.in_valid   = 1'b0;
        bus.alu_result = '0;
        bus.cpsr_in    = '0;
        bus.store_data = '0;
        bus.rd         = '0;
        bus.rd_we      = 1'b0;
        bus.set_flags  = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_ack    = 1'b0;
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (!bus.in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, ":in_ready_wait"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic driveInstr(input logic ld, input logic st, input logic [32:0] alu,
                              input logic [31:0] sd, input logic [3:0] rd, input logic rdWe,
                              input logic sf, input logic [31:0] cpsr);
        bus.in_valid   = 1'b1;
        bus.is_load    = ld;
        bus.is_store   = st;
        bus.alu_result = alu;
        bus.store_data = sd;
        bus.rd         = rd;
        bus.rd_we      = rdWe;
        bus.set_flags  = sf;
        bus.cpsr_in    = cpsr;
    endtask

    // Runs one instruction from acceptance through writeback, then confirms the stage is free again.
    task automatic applyStimulus(input vec_t v);
        waitReady(v.name);
        driveInstr(v.isLoad, v.isStore, v.alu, v.storeData, v.rd, v.rdWe, v.setFlags, v.cpsrIn);
        @(negedge clk);
        clearInputs();
        if (v.isLoad || v.isStore) begin
            for (int j = 0; j <= v.ackDelay; j++) begin
                checkOutput({v.name, ":mem_req"}, {31'd0, bus.mem_req}, 32'd1);
                checkOutput({v.name, ":mem_addr"}, bus.mem_addr, v.alu[31:0]);
                checkOutput({v.name, ":mem_we"}, {31'd0, bus.mem_we}, {31'd0, v.isStore});
                if (v.isStore)
                    checkOutput({v.name, ":mem_wdata"}, bus.mem_wdata, v.storeData);
                bus.mem_ack   = (j == v.ackDelay);
                bus.mem_rdata = v.rdata;
                @(negedge clk);
            end
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            checkOutput({v.name, ":mem_req_drop"}, {31'd0, bus.mem_req}, 32'd0);
        end
        checkOutput({v.name, ":rf_we"}, {31'd0, bus.rf_we}, {31'd0, v.expRfWe});
        if (v.expRfWe) begin
            checkOutput({v.name, ":rf_waddr"}, {28'd0, bus.rf_waddr}, {28'd0, v.rd});
            checkOutput({v.name, ":rf_wdata"}, bus.rf_wdata, v.expRfWdata);
        end
        checkOutput({v.name, ":cpsr_we"}, {31'd0, bus.cpsr_we}, {31'd0, v.expCpsrWe});
        if (v.expCpsrWe)
            checkOutput({v.name, ":cpsr_wdata"}, bus.cpsr_wdata, v.expCpsr);
        checkOutput({v.name, ":mem_fault"}, {31'd0, bus.mem_fault}, 32'd0);
        checkOutput({v.name, ":in_ready_wb"}, {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        checkOutput({v.name, ":in_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
        checkOutput({v.name, ":rf_we_pulse"}, {31'd0, bus.rf_we}, 32'd0);
        checkOutput({v.name, ":cpsr_we_pulse"}, {31'd0, bus.cpsr_we}, 32'd0);
    endtask

    initial begin
        int reqCycles;
        int guard;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clearInputs();

        vecs[0] = '{name:"alu_basic", isLoad:0, isStore:0, alu:33'h0_0000_0005, storeData:0, rd:3,
                    rdWe:1, setFlags:1, cpsrIn:32'h0, ackDelay:0, rdata:0,
                    expRfWe:1, expRfWdata:32'h5, expCpsrWe:1, expCpsr:32'h0};
        vecs[1] = '{name:"alu_ovf", isLoad:0, isStore:0, alu:33'h1_8000_0000, storeData:0, rd:15,
                    rdWe:1, setFlags:1, cpsrIn:32'h9000_0000, ackDelay:0, rdata:0,
                    expRfWe:1, expRfWdata:32'h8000_0000, expCpsrWe:1, expCpsr:32'h9000_0000};
        vecs[2] = '{name:"alu_nowrite", isLoad:0, isStore:0, alu:33'h0_0000_1234, storeData:0, rd:7,
                    rdWe:0, setFlags:0, cpsrIn:32'hF000_0000, ackDelay:0, rdata:0,
                    expRfWe:0, expRfWdata:32'h0, expCpsrWe:0, expCpsr:32'h0};
        vecs[3] = '{name:"load_neg", isLoad:1, isStore:0, alu:33'h0_0000_0100, storeData:0, rd:2,
                    rdWe:1, setFlags:1, cpsrIn:32'h0, ackDelay:2, rdata:32'h8000_0000,
                    expRfWe:1, expRfWdata:32'h8000_0000, expCpsrWe:1, expCpsr:32'h8000_0000};
        vecs[4] = '{name:"load_zero", isLoad:1, isStore:0, alu:33'h0_0000_0044, storeData:0, rd:9,
                    rdWe:1, setFlags:1, cpsrIn:32'hF000_0000, ackDelay:0, rdata:32'h0,
                    expRfWe:1, expRfWdata:32'h0, expCpsrWe:1, expCpsr:32'h4000_0000};
        vecs[5] = '{name:"store", isLoad:0, isStore:1, alu:33'h0_0000_0020, storeData:32'hDEAD_BEEF, rd:1,
                    rdWe:1, setFlags:0, cpsrIn:32'h0, ackDelay:1, rdata:32'h0,
                    expRfWe:0, expRfWdata:32'h0, expCpsrWe:0, expCpsr:32'h0};
        vecs[6] = '{name:"load_noflags", isLoad:1, isStore:0, alu:33'h0_0000_0300, storeData:0, rd:4,
                    rdWe:1, setFlags:0, cpsrIn:32'h0, ackDelay:3, rdata:32'h1234_5678,
                    expRfWe:1, expRfWdata:32'h1234_5678, expCpsrWe:0, expCpsr:32'h0};
        vecs[7] = '{name:"load_ack_last", isLoad:1, isStore:0, alu:33'h0_0000_0080, storeData:0, rd:5,
                    rdWe:1, setFlags:1, cpsrIn:32'h0, ackDelay:15, rdata:32'hCAFE_0000,
                    expRfWe:1, expRfWdata:32'hCAFE_0000, expCpsrWe:1, expCpsr:32'h8000_0000};

        // Reset state, then in_ready rising only on the first clock after release.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset:in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("reset:mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset:rf_we", {31'd0, bus.rf_we}, 32'd0);
        checkOutput("reset:cpsr_we", {31'd0, bus.cpsr_we}, 32'd0);
        checkOutput("reset:mem_fault", {31'd0, bus.mem_fault}, 32'd0);
        checkOutput("reset:rf_wdata", bus.rf_wdata, 32'd0);
        checkOutput("reset:mem_addr", bus.mem_addr, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("release:in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("release:in_ready_high", {31'd0, bus.in_ready}, 32'd1);

        // A stray ack while idle must do nothing.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        @(negedge clk);
        clearInputs();
        checkOutput("idle_ack:rf_we", {31'd0, bus.rf_we}, 32'd0);
        checkOutput("idle_ack:mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("idle_ack:in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i]);

        // Misaligned load faults without ever requesting memory.
        waitReady("misaligned");
        driveInstr(1'b1, 1'b0, 33'h0_0000_0102, 32'h0, 4'd6, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        clearInputs();
        checkOutput("misaligned:mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("misaligned:mem_fault", {31'd0, bus.mem_fault}, 32'd1);
        checkOutput("misaligned:rf_we", {31'd0, bus.rf_we}, 32'd0);
        checkOutput("misaligned:cpsr_we", {31'd0, bus.cpsr_we}, 32'd0);
        @(negedge clk);
        checkOutput("misaligned:fault_pulse", {31'd0, bus.mem_fault}, 32'd0);
        checkOutput("misaligned:mem_req_after", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("misaligned:in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Store with no ack: exactly MEM_TIMEOUT request cycles, then a fault pulse.
        waitReady("timeout");
        driveInstr(1'b0, 1'b1, 33'h0_0000_0040, 32'h0000_0011, 4'd8, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        clearInputs();
        reqCycles = 0;
        guard     = 0;
        while (bus.mem_req && guard < 40) begin
            reqCycles++;
            guard++;
            @(negedge clk);
        end
        checkOutput("timeout:req_cycles", reqCycles, 32'd16);
        checkOutput("timeout:mem_fault", {31'd0, bus.mem_fault}, 32'd1);
        checkOutput("timeout:rf_we", {31'd0, bus.rf_we}, 32'd0);
        @(negedge clk);
        checkOutput("timeout:fault_pulse", {31'd0, bus.mem_fault}, 32'd0);
        checkOutput("timeout:in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Reset during the second request cycle kills the access outright.
        waitReady("reset_mid");
        driveInstr(1'b1, 1'b0, 33'h0_0000_0200, 32'h0, 4'd6, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        clearInputs();
        checkOutput("reset_mid:req_cycle1", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        checkOutput("reset_mid:req_cycle2", {31'd0, bus.mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid:req_async_drop", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset_mid:in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("reset_mid:rf_we_held", {31'd0, bus.rf_we}, 32'd0);
            checkOutput("reset_mid:cpsr_we_held", {31'd0, bus.cpsr_we}, 32'd0);
        end
        reset = 1'b0;
        #1;
        checkOutput("reset_mid:in_ready_release", {31'd0, bus.in_ready}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_00AA;
        @(negedge clk);
        clearInputs();
        checkOutput("reset_mid:in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("reset_mid:rf_we_after", {31'd0, bus.rf_we}, 32'd0);
        checkOutput("reset_mid:cpsr_we_after", {31'd0, bus.cpsr_we}, 32'd0);
        checkOutput("reset_mid:mem_req_after", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        checkOutput("reset_mid:rf_we_late", {31'd0, bus.rf_we}, 32'd0);
        checkOutput("reset_mid:cpsr_we_late", {31'd0, bus.cpsr_we}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Sits directly downstream of the execute stage.
- Consumes the 33-bit ALU result and the candidate CPSR value, plus control from decode.
- Performs the optional data-memory access through a req/ack handshake, then issues a one-cycle register-file and CPSR write.
- Back-pressures execute with in_ready while an access is outstanding.

Parameters:
- REG_ADDR_W, 4, destination register index width.
- MEM_TIMEOUT, 16, cycles mem_req may wait for mem_ack before a fault is raised (≥1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  execute presents an instruction
- in_ready  output  1  stage can accept (high only in IDLE)
- alu_result  input  33  execute result; [31:0] is data/address, [32] is overflow
- cpsr_in  input  32  execute-computed CPSR (N,Z,C,V in [31:28])
- store_data  input  32  register value to store
- rd  input  REG_ADDR_W  destination register
- rd_we  input  1  instruction writes rd
- set_flags  input  1  instruction updates CPSR
- is_load  input  1  memory read; alu_result[31:0] is the address
- is_store  input  1  memory write (is_load and is_store never both high)
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  32  word address
- mem_wdata  output  32  store data
- mem_rdata  input  32  load data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse
- rf_we  output  1  register-file write strobe
- rf_waddr  output  REG_ADDR_W  write index
- rf_wdata  output  32  write data
- cpsr_we  output  1  CPSR write strobe
- cpsr_wdata  output  32  new CPSR
- mem_fault  output  1  one-cycle pulse: misaligned address or timeout

Behaviour:
- Reset value of all outputs is 0, including in_ready; state is IDLE.
  - in_ready is 0 while reset is asserted and goes to 1 on the first clock after release.
  - Reset asserted mid-access drops mem_req immediately (async), discards the latched instruction, and produces no rf/cpsr write.
- All outputs are registered. The FSM has four states: IDLE, MEM, WB, FAULT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch all inputs.
  - If is_load|is_store and alu_result[1:0]!=0, go to FAULT.
  - Otherwise, if is_load|is_store, go to MEM with mem_req=1, mem_we=is_store, mem_addr=alu_result[31:0], mem_wdata=store_data (request visible the cycle after acceptance).
  - Otherwise go to WB.
- MEM:
  - in_ready=0. mem_req, mem_we, mem_addr and mem_wdata are held stable until ack.
  - A wait counter starts at 0 on entry and increments each cycle without ack.
  - On mem_ack: drop mem_req next cycle, latch mem_rdata when is_load, go to WB.
  - If the counter reaches MEM_TIMEOUT-1 without ack: drop mem_req, go to FAULT.
  - mem_ack arriving in the same cycle as the final timeout count is treated as success; ack wins.
  - mem_ack outside MEM is ignored.
- WB: one cycle.
  - rf_we = rd_we & ~is_store.
  - rf_waddr = rd.
  - rf_wdata = is_load ? loaded data : alu_result[31:0].
  - cpsr_we = set_flags. For non-loads, cpsr_wdata = cpsr_in. For loads, cpsr_wdata = {data[31], data==0, 30'b0}.
  - Next state is IDLE.
- FAULT: one cycle, mem_fault=1, no rf/cpsr write, then IDLE.
- Strobes rf_we, cpsr_we and mem_fault are single-cycle pulses; other outputs hold their last value.
- Latency from acceptance to writeback:
  - ALU op: WB strobe 1 cycle after acceptance; 2 cycles per instruction.
  - Load/store with ack k cycles after mem_req rises: WB at acceptance+k+2.
- Back-to-back: the next instruction can be accepted the cycle after WB or FAULT (IDLE).

Test Plan:
- ALU op: in_valid with alu_result=0x0_0000_0005, rd=3, rd_we=1, set_flags=1, cpsr_in=0x0 -> the next cycle shows rf_we=1, rf_waddr=3, rf_wdata=5, cpsr_we=1, cpsr_wdata=0; in_ready returns to 1 the following cycle.
- Load: alu_result=0x100, is_load, rd=2, with mem_ack and mem_rdata=0x8000_0000 on the third cycle of mem_req -> mem_addr=0x100 stable throughout, rf_wdata=0x8000_0000, and with set_flags=1 cpsr_wdata=0x8000_0000.
- Store: alu_result=0x20, store_data=0xDEAD_BEEF, rd_we=1 -> mem_we=1 and mem_wdata=0xDEADBEEF; after ack, rf_we stays 0 (store suppresses rd_we).
- Misaligned address: load at 0x102 -> mem_req never rises, mem_fault pulses one cycle, no rf_we.
- Timeout: store with mem_ack tied low, MEM_TIMEOUT=16 -> mem_req is high for exactly 16 cycles, then mem_fault pulses. In a separate run, ack on exactly the 16th cycle -> success, no fault.
- Reset mid-MEM: assert reset on the 2nd cycle of mem_req -> mem_req falls asynchronously, no rf_we/cpsr_we ever, in_ready=1 the first clock after release.
